mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master arbiter and sequencer for the read/write port of the shared byte-addressed memory. It accepts independent requests from master 0 (CPU load/store unit) and master 1 (debug/DMA). It grants one at a time, drives the memory's address/write/size/write-data inputs for exactly one access cycle, and returns read data and error status to the winner with a one-cycle acknowledge. The memory's read-only port is untouched.

## Interface
Parameters:
- N, 1024: memory size in bytes; requests outside [0, N) are rejected without touching memory.

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset; one clock, synchronous, active-high
- mK_req  in  1  request from master K (K = 0, 1); held until mK_ack
- mK_write  in  1  1 = write, 0 = read
- mK_addr  in  32  byte address
- mK_wdata  in  32  write data, right-aligned for HALFWORD/BYTE
- mK_tsize  in  tsize_e  WORD/HALFWORD/BYTE
- mK_ack  out  1  one-cycle completion pulse to master K
- mK_rdata  out  32  read data, valid while mK_ack = 1
- mK_err  out  1  error status, valid while mK_ack = 1
- mem_address  out  32  to memory address
- mem_write  out  1  to memory write
- mem_write_data  out  32  to memory write_data
- mem_tsize  out  tsize_e  to memory tsize
- mem_data  in  32  from memory data (combinational read)
- mem_rerror  in  1  from memory rerror
- mem_werror  in  1  from memory werror (registered by memory on write edge)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner and latch its write, addr, wdata, tsize and index into internal registers.
  - Range check: size bytes = 4/2/1 for WORD/HALFWORD/BYTE. Out of range when addr > N - size, computed in 33 bits so no wraparound.
  - If out of range: set err_q = 1 and rdata_q = 0, then go to RESP. ACCESS is skipped and mem_write is never asserted.
  - Else go to ACCESS.
- ACCESS:
  - mem_address, mem_tsize and mem_write_data come from the latched registers.
  - mem_write = latched write AND NOT rst.
  - Read: capture mem_data into rdata_q and mem_rerror into err_q at the end of the cycle.
  - Write: set rdata_q = 0.
  - Go to RESP.
- RESP:
  - Assert ack of the latched master for one cycle with rdata_q.
  - err is driven from err_q for reads and range errors, and from mem_werror for in-range writes.
  - The other master's ack stays 0.
  - Go to IDLE.
- Outside ACCESS: mem_address = 0, mem_write = 0, mem_write_data = 0, mem_tsize = WORD.
- mK_rdata and mK_err are 0 whenever mK_ack = 0.
- Arbitration: see Configuration. The priority pointer last_q updates only when a grant is made in IDLE.
- Request fields are sampled only in IDLE; changes while the master is waiting are ignored.

## Timing
- Request sampled in IDLE at edge t. ACCESS occupies cycle t+1. Ack is high during cycle t+2. Back in IDLE at cycle t+3.
- Range-rejected request: ack is high in cycle t+1.
- Peak throughput is one access per 3 cycles.
- A master must hold req and its fields until it sees ack. If req is still high in the IDLE cycle after ack, that is a new request.
- Reset values: state IDLE, last_q = 1 (so master 0 wins first), all acks 0, rdata 0, err 0, all mem_* outputs at their idle values.
- Reset asserted during ACCESS: mem_write is forced to 0 that cycle (no memory write), no ack is issued, and the block returns to IDLE.
- Reset asserted during RESP: the ack is suppressed.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. When both masters request in IDLE, the master not equal to last_q wins. With a single requester, that requester wins.
- MEM_ARB_RR_EN undefined: fixed priority. Master 0 always wins ties, and last_q is still maintained but unused. Master 1 can starve under continuous master 0 traffic.

## Test plan
- Single read: m0 WORD read at addr 0x10, memory holds bytes 11 22 33 44 → m0_ack pulses 2 cycles after request, m0_rdata = 0x11223344, m0_err = 0, mem_write never asserted.
- Write then read: m1 HALFWORD write 0xBEEF at 0x20, then m1 HALFWORD read at 0x20 → mem_write high exactly one cycle; read returns 0x0000BEEF, err = 0.
- Alignment and range errors:
  - m0 WORD write at 0x13 → m0_err = 1, memory unchanged.
  - m0 BYTE read at N (1024) → ack in next cycle, err = 1, no ACCESS cycle.
  - WORD read at N-4 → succeeds.
- Contention: both masters request continuously from reset → with MEM_ARB_RR_EN grants alternate m0, m1, m0, m1; without it m0 is granted every time and m1_ack never asserts.
- Reset mid-write: rst asserted in the ACCESS cycle of an m1 write to 0x40 → mem_write = 0, byte at 0x40 unchanged, no ack, state IDLE, next m0 request served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter/sequencer for the shared memory read/write port; tie-break is round-robin with MEM_ARB_RR_EN, fixed m0 priority otherwise.
// Latency: ack 2 cycles after grant (1 cycle for range rejects); masters hold req until ack, one access per 3 cycles.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        WORD     = 2'b00,
        HALFWORD = 2'b01,
        BYTE     = 2'b10
    } tsize_e;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  tsize_e      m0_tsize,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  tsize_e      m1_tsize,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    output tsize_e      mem_tsize,
    input  logic [31:0] mem_data,
    input  logic        mem_rerror,
    input  logic        mem_werror
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  state_q;
    logic        last_q;
    logic        wr_q;
    logic        idx_q;
    logic        err_q;
    logic        oor_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    tsize_e      tsize_q;

    logic        any_req;
    logic        gnt;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    tsize_e      sel_tsize;
    logic [32:0] size_b;
    logic        oor;

    always_comb begin
        any_req = m0_req | m1_req;
`ifdef MEM_ARB_RR_EN
        gnt = (m0_req && m1_req) ? ~last_q : ~m0_req;
`else
        // last_q term is redundant here; the pointer is tracked identically in both builds
        gnt = ~m0_req & ~(m0_req & last_q);
`endif
        sel_write = gnt ? m1_write : m0_write;
        sel_addr  = gnt ? m1_addr  : m0_addr;
        sel_wdata = gnt ? m1_wdata : m0_wdata;
        sel_tsize = gnt ? m1_tsize : m0_tsize;
        case (sel_tsize)
            HALFWORD: size_b = 33'd2;
            BYTE:     size_b = 33'd1;
            default:  size_b = 33'd4;
        endcase
        // 33-bit compare so addresses near 2^32 cannot wrap into range
        oor = {1'b0, sel_addr} > (33'(N) - size_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            idx_q   <= 1'b0;
            err_q   <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            tsize_q <= WORD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        wr_q    <= sel_write;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        tsize_q <= sel_tsize;
                        idx_q   <= gnt;
                        last_q  <= gnt;
                        oor_q   <= oor;
                        if (oor) begin
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wr_q) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                    end else begin
                        rdata_q <= mem_data;
                        err_q   <= mem_rerror;
                    end
                    state_q <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic in_access;
    logic resp;
    logic resp_err;

    always_comb begin
        in_access      = (state_q == S_ACCESS);
        mem_address    = in_access ? addr_q  : 32'd0;
        mem_write_data = in_access ? wdata_q : 32'd0;
        mem_tsize      = in_access ? tsize_q : WORD;
        mem_write      = in_access & wr_q & ~rst;
        resp           = (state_q == S_RESP) & ~rst;
        // in-range writes report the error the memory registered on the write edge
        resp_err       = (wr_q & ~oor_q) ? mem_werror : err_q;
        m0_ack         = resp & ~idx_q;
        m1_ack         = resp & idx_q;
        m0_rdata       = m0_ack ? rdata_q : 32'd0;
        m1_rdata       = m1_ack ? rdata_q : 32'd0;
        m0_err         = m0_ack & resp_err;
        m1_err         = m1_ack & resp_err;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-array memory model; expected acks go into a scoreboard queue checked by a monitor.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_write = 0, m1_req = 0, m1_write = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    tsize_e      m0_tsize = WORD, m1_tsize = WORD;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_write_data, mem_data;
    logic        mem_write, mem_rerror;
    logic        mem_werror = 1'b0;
    tsize_e      mem_tsize;

    mem_port_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_tsize(m0_tsize),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_tsize(m1_tsize),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_address(mem_address), .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_tsize(mem_tsize), .mem_data(mem_data), .mem_rerror(mem_rerror), .mem_werror(mem_werror)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vectors = 0;
    int misc = 0;
    int wr_cnt = 0;
    int m1_acks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Big-endian byte memory: combinational read, write error registered on the write edge.
    logic [7:0] mem [0:N-1];

    function automatic logic misaligned(input logic [31:0] a, input tsize_e ts);
        case (ts)
            WORD:     return (a[1:0] != 2'b00) || (a > 32'(N - 4));
            HALFWORD: return a[0] || (a > 32'(N - 2));
            default:  return a > 32'(N - 1);
        endcase
    endfunction

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < N; i++) mem[i] <= 8'h00;
            mem[16'h10] <= 8'h11; mem[16'h11] <= 8'h22; mem[16'h12] <= 8'h33; mem[16'h13] <= 8'h44;
            mem[16'h40] <= 8'h5A;
            mem[1020] <= 8'hA1; mem[1021] <= 8'hB2; mem[1022] <= 8'hC3; mem[1023] <= 8'hD4;
        end
        if (mem_write) begin
            wr_cnt = wr_cnt + 1;
            mem_werror <= misaligned(mem_address, mem_tsize);
            if (!misaligned(mem_address, mem_tsize)) begin
                case (mem_tsize)
                    WORD: begin
                        mem[mem_address]     <= mem_write_data[31:24];
                        mem[mem_address + 1] <= mem_write_data[23:16];
                        mem[mem_address + 2] <= mem_write_data[15:8];
                        mem[mem_address + 3] <= mem_write_data[7:0];
                    end
                    HALFWORD: begin
                        mem[mem_address]     <= mem_write_data[15:8];
                        mem[mem_address + 1] <= mem_write_data[7:0];
                    end
                    default: mem[mem_address] <= mem_write_data[7:0];
                endcase
            end
        end
    end

    always_comb begin
        mem_data   = 32'd0;
        mem_rerror = misaligned(mem_address, mem_tsize);
        if (!mem_rerror) begin
            case (mem_tsize)
                WORD:     mem_data = {mem[mem_address], mem[mem_address + 1], mem[mem_address + 2], mem[mem_address + 3]};
                HALFWORD: mem_data = {16'd0, mem[mem_address], mem[mem_address + 1]};
                default:  mem_data = {24'd0, mem[mem_address]};
            endcase
        end
    end

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_port(input int k, input logic a, input logic [31:0] rd, input logic e);
        exp_t x;
        if (a) begin
            if (k == 1) m1_acks++;
            vectors++;
            if (sbq.size() == 0) begin
                misc++;
                $display("FAIL unexpected_ack m%0d at cycle %0d rdata 0x%08h err %0b", k, cyc, rd, e);
            end else begin
                x = sbq.pop_front();
                if (x.m != k || x.rd !== rd || x.err !== e || x.cyc != cyc) begin
                    misc++;
                    $display("FAIL ack_m%0d: got m%0d rdata 0x%08h err %0b cycle %0d, expected m%0d rdata 0x%08h err %0b cycle %0d",
                             k, k, rd, e, cyc, x.m, x.rd, x.err, x.cyc);
                end
            end
        end else if (rd !== 32'd0 || e !== 1'b0) begin
            vectors++;
            misc++;
            $display("FAIL idle_out_m%0d: rdata 0x%08h err %0b while ack low (cycle %0d)", k, rd, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        mon_port(0, m0_ack, m0_rdata, m0_err);
        mon_port(1, m1_ack, m1_rdata, m1_err);
    end

    // Called at posedge+1 with the DUT idle; holds req until ack then drops it.
    task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input tsize_e ts, input logic [31:0] erd, input logic eerr, input int lat);
        bit seen = 0;
        if (k == 0) begin
            m0_write = w; m0_addr = a; m0_wdata = wd; m0_tsize = ts; m0_req = 1'b1;
        end else begin
            m1_write = w; m1_addr = a; m1_wdata = wd; m1_tsize = ts; m1_req = 1'b1;
        end
        sbq.push_back('{k, erd, eerr, cyc + lat});
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (k == 0) ? m0_ack : m1_ack;
        end
        if (!seen) begin
            vectors++;
            misc++;
            $display("FAIL ack_timeout m%0d addr 0x%08h: got no ack, expected ack in %0d cycles", k, a, lat);
        end
        @(posedge clk);
        #1;
        if (k == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    int w0;
    int c0;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_m1_ack", {31'd0, m1_ack}, 32'd0);
        check("idle_mem_address", mem_address, 32'd0);
        check("idle_mem_wdata", mem_write_data, 32'd0);
        check("idle_mem_tsize", {30'd0, mem_tsize}, {30'd0, WORD});
        @(posedge clk); #1;

        w0 = wr_cnt;
        issue(0, 1'b0, 32'h10, 32'h0, WORD, 32'h11223344, 1'b0, 2);
        check("read_no_write", wr_cnt - w0, 0);

        w0 = wr_cnt;
        issue(1, 1'b1, 32'h20, 32'h0000BEEF, HALFWORD, 32'h0, 1'b0, 2);
        check("hw_write_pulses", wr_cnt - w0, 1);
        issue(1, 1'b0, 32'h20, 32'h0, HALFWORD, 32'h0000BEEF, 1'b0, 2);
        check("hw_mem_bytes", {16'd0, mem[16'h20], mem[16'h21]}, 32'h0000BEEF);

        issue(0, 1'b1, 32'h13, 32'hDEADBEEF, WORD, 32'h0, 1'b1, 2);
        check("misaligned_unchanged", {mem[16'h13], mem[16'h14], mem[16'h15], mem[16'h16]}, 32'h44000000);

        w0 = wr_cnt;
        issue(0, 1'b0, 32'd1024, 32'h0, BYTE, 32'h0, 1'b1, 1);
        issue(1, 1'b1, 32'd1023, 32'h1234, HALFWORD, 32'h0, 1'b1, 1);
        check("oor_no_access", wr_cnt - w0, 0);
        issue(1, 1'b0, 32'd1020, 32'h0, WORD, 32'hA1B2C3D4, 1'b0, 2);

        // Contention from reset: both masters hold requests for four grants.
        rst = 1'b1;
        m0_write = 1'b0; m0_addr = 32'h10; m0_tsize = WORD; m0_req = 1'b1;
        m1_write = 1'b0; m1_addr = 32'h20; m1_tsize = WORD; m1_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cyc;
        w0 = m1_acks;
`ifdef MEM_ARB_RR_EN
        sbq.push_back('{0, 32'h11223344, 1'b0, c0 + 2});
        sbq.push_back('{1, 32'hBEEF0000, 1'b0, c0 + 5});
        sbq.push_back('{0, 32'h11223344, 1'b0, c0 + 8});
        sbq.push_back('{1, 32'hBEEF0000, 1'b0, c0 + 11});
`else
        for (int i = 0; i < 4; i++) sbq.push_back('{0, 32'h11223344, 1'b0, c0 + 2 + 3 * i});
`endif
        repeat (12) @(posedge clk);
        #1;
        m0_req = 1'b0; m1_req = 1'b0;
`ifdef MEM_ARB_RR_EN
        check("contention_m1_acks", m1_acks - w0, 2);
`else
        check("contention_m1_acks", m1_acks - w0, 0);
`endif
        repeat (2) @(posedge clk); #1;

        // Reset lands in the ACCESS cycle of an m1 byte write.
        w0 = m1_acks;
        m1_write = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h000000AB; m1_tsize = BYTE; m1_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; m1_req = 1'b0;
        @(negedge clk);
        check("rst_access_mem_write", {31'd0, mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("rst_write_no_ack", m1_acks - w0, 0);
        check("rst_write_byte", {24'd0, mem[16'h40]}, 32'h5A);
        issue(0, 1'b0, 32'h40, 32'h0, BYTE, 32'h0000005A, 1'b0, 2);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
